// File: rtl/fast_cycle_sequencer_pkg.sv
// Shared types and constants for the fast-clock cycle sequencer slice.
package beeb816_clk_pkg;

    localparam int CNT_W = 8;

    localparam int WS_DIV2_DEF     = 2;
    localparam int WS_DIV4_DEF     = 1;
    localparam int TIMEOUT_DEF     = 255;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_REQ     = 2'd2,
        ST_RELEASE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/fast_cycle_sequencer_if.sv
// CPU-cycle and host-handshake signals of the sequencer, plus its FSM state for observation.
interface fast_cycle_sequencer_if;
    import beeb816_clk_pkg::*;

    // Host handshake is four-phase: host_req rises, host_ack rises, host_req falls,
    // host_ack falls. The sequencer only ever sees host_ack through its synchroniser.
    logic       div4not2;
    logic       cyc_valid;
    logic       cyc_slow;
    logic       host_ack;
    logic       err_clr;
    logic       cpu_rdy;
    logic       host_req;
    logic       busy;
    logic       timeout_err;
    seq_state_t state;

    modport master (
        output div4not2, cyc_valid, cyc_slow, host_ack, err_clr,
        input  cpu_rdy, host_req, busy, timeout_err, state
    );

    modport slave (
        input  div4not2, cyc_valid, cyc_slow, host_ack, err_clr,
        output cpu_rdy, host_req, busy, timeout_err, state
    );

endinterface

// File: rtl/fast_cycle_sequencer_sync.sv
// Multi-flop synchroniser for a single asynchronous level; resets to 0.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetb,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/fast_cycle_sequencer.sv
// Wait-state inserter for fast accesses and req/ack sequencer for host accesses,
// driving CPU RDY from the divided fast clock.
module fast_cycle_sequencer
    import beeb816_clk_pkg::*;
#(
    parameter int WS_DIV2     = WS_DIV2_DEF,
    parameter int WS_DIV4     = WS_DIV4_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                   gated_clk_w,
    input  logic                   resetb,
    fast_cycle_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] WS2     = CNT_W'(WS_DIV2);
    localparam logic [CNT_W-1:0] WS4     = CNT_W'(WS_DIV4);

    logic             ack_s;
    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [CNT_W-1:0] ws;
    logic             err_set;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk    (gated_clk_w),
        .resetb (resetb),
        .d      (bus.host_ack),
        .q      (ack_s)
    );

    always_comb begin
        ws        = bus.div4not2 ? WS4 : WS2;
        state_nxt = state;
        count_nxt = count;
        err_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cyc_valid) begin
                    if (bus.cyc_slow) begin
                        state_nxt = ST_REQ;
                        count_nxt = '0;
                    end else if (ws != '0) begin
                        state_nxt = ST_WAIT;
                        count_nxt = ws - CNT_ONE;
                    end
                end
            end
            ST_WAIT: begin
                if (count == '0) state_nxt = ST_IDLE;
                else             count_nxt = count - CNT_ONE;
            end
            ST_REQ: begin
                if (ack_s) begin
                    state_nxt = ST_RELEASE;
                    count_nxt = '0;
                end else if (count == CNT_MAX) begin
                    // Counter stays saturated, so a still-high ack in RELEASE times out at once.
                    err_set   = 1'b1;
                    state_nxt = ST_RELEASE;
                end else begin
                    count_nxt = count + CNT_ONE;
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    state_nxt = ST_IDLE;
                end else if (count == CNT_MAX) begin
                    err_set   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    count_nxt = count + CNT_ONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave the flops glitch-free.
    always_ff @(posedge gated_clk_w or negedge resetb) begin
        if (!resetb) begin
            state           <= ST_IDLE;
            count           <= '0;
            bus.cpu_rdy     <= 1'b1;
            bus.host_req    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            bus.cpu_rdy  <= (state_nxt == ST_IDLE);
            bus.host_req <= (state_nxt == ST_REQ);
            bus.busy     <= (state_nxt != ST_IDLE);
            if (err_set)          bus.timeout_err <= 1'b1;
            else if (bus.err_clr) bus.timeout_err <= 1'b0;
        end
    end

    assign bus.state = state;

endmodule

// File: tb/tb_fast_cycle_sequencer.sv
// Bench for fast_cycle_sequencer: directed scenarios plus randomized traffic against a cycle-level model.
module tb_fast_cycle_sequencer;
    import beeb816_clk_pkg::*;

    localparam int WS2 = 2;
    localparam int WS4 = 0;
    localparam int TMO = 8;
    localparam int SS  = 2;

    logic gated_clk_w;
    logic resetb;
    bit   clk_en;

    int total = 0;
    int bad   = 0;

    fast_cycle_sequencer_if bus_if ();

    fast_cycle_sequencer #(
        .WS_DIV2     (WS2),
        .WS_DIV4     (WS4),
        .TIMEOUT     (TMO),
        .SYNC_STAGES (SS)
    ) dut (
        .gated_clk_w (gated_clk_w),
        .resetb      (resetb),
        .bus         (bus_if)
    );

    // ---------------- clock / reset ----------------
    initial begin
        gated_clk_w = 1'b0;
        forever begin
            #5;
            if (clk_en) gated_clk_w = ~gated_clk_w;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 fast wait, 2 request, 3 release
    int         m_phase;
    int         m_left;
    int         m_edges;
    bit         m_err;
    bit         ack_hist[$];
    logic [3:0] exp_q[$];

    task automatic model_reset();
        m_phase  = 0;
        m_left   = 0;
        m_edges  = 0;
        m_err    = 1'b0;
        ack_hist = {};
        for (int i = 0; i < SS; i++) ack_hist.push_back(1'b0);
        exp_q = {};
    endtask

    task automatic model_step();
        bit a;
        bit timed_out;
        int ws;
        a = ack_hist.pop_front();
        ack_hist.push_back(bus_if.host_ack);
        timed_out = 1'b0;
        case (m_phase)
            0: if (bus_if.cyc_valid) begin
                if (bus_if.cyc_slow) begin
                    m_phase = 2;
                    m_edges = 0;
                end else begin
                    ws = bus_if.div4not2 ? WS4 : WS2;
                    if (ws > 0) begin
                        m_phase = 1;
                        m_left  = ws;
                    end
                end
            end
            1: begin
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
            2: if (a) begin
                m_phase = 3;
                m_edges = 0;
            end else begin
                m_edges++;
                if (m_edges >= TMO) begin
                    timed_out = 1'b1;
                    m_phase   = 3;
                end
            end
            default: if (!a) begin
                m_phase = 0;
            end else begin
                m_edges++;
                if (m_edges >= TMO) begin
                    timed_out = 1'b1;
                    m_phase   = 0;
                end
            end
        endcase
        if (timed_out)           m_err = 1'b1;
        else if (bus_if.err_clr) m_err = 1'b0;
        exp_q.push_back({m_phase != 0, m_phase == 2, m_phase == 0, m_err});
    endtask

    always @(negedge resetb) model_reset();

    always @(posedge gated_clk_w) if (resetb) model_step();

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge gated_clk_w) begin
        logic [3:0] e;
        if (resetb && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("busy/req/rdy/err", {4'h0, bus_if.busy, bus_if.host_req, bus_if.cpu_rdy,
                  bus_if.timeout_err}, {4'h0, e});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge gated_clk_w);
    endtask

    task automatic start_cycle(input bit slow, input bit div4);
        bus_if.cyc_valid = 1'b1;
        bus_if.cyc_slow  = slow;
        bus_if.div4not2  = div4;
        tick();
        bus_if.cyc_valid = 1'b0;
        bus_if.cyc_slow  = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lowcnt;
        bit found;
        int delay;

        clk_en = 1'b1;
        resetb = 1'b0;
        bus_if.div4not2  = 1'b0;
        bus_if.cyc_valid = 1'b0;
        bus_if.cyc_slow  = 1'b0;
        bus_if.host_ack  = 1'b0;
        bus_if.err_clr   = 1'b0;
        model_reset();

        #12;
        check("reset_cpu_rdy", {7'd0, bus_if.cpu_rdy}, 8'd1);
        check("reset_host_req", {7'd0, bus_if.host_req}, 8'd0);
        check("reset_busy", {7'd0, bus_if.busy}, 8'd0);
        check("reset_timeout_err", {7'd0, bus_if.timeout_err}, 8'd0);
        resetb = 1'b1;
        repeat (3) tick();

        // fast access, div2, two wait states
        start_cycle(1'b0, 1'b0);
        check("fast2_rdy_e0", {7'd0, bus_if.cpu_rdy}, 8'd0);
        check("fast2_req_e0", {7'd0, bus_if.host_req}, 8'd0);
        tick();
        check("fast2_rdy_e1", {7'd0, bus_if.cpu_rdy}, 8'd0);
        tick();
        check("fast2_rdy_e2", {7'd0, bus_if.cpu_rdy}, 8'd1);
        check("fast2_busy_e2", {7'd0, bus_if.busy}, 8'd0);

        // fast access, div4, zero wait states
        bus_if.div4not2  = 1'b1;
        bus_if.cyc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fast4_rdy", {7'd0, bus_if.cpu_rdy}, 8'd1);
            check("fast4_busy", {7'd0, bus_if.busy}, 8'd0);
        end
        bus_if.cyc_valid = 1'b0;
        bus_if.div4not2  = 1'b0;
        tick();

        // slow access, host answers 3 cycles late each way
        start_cycle(1'b1, 1'b0);
        check("slow_req_up", {7'd0, bus_if.host_req}, 8'd1);
        check("slow_rdy_low", {7'd0, bus_if.cpu_rdy}, 8'd0);
        repeat (3) tick();
        bus_if.host_ack = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = !bus_if.host_req;
        end
        check("slow_req_fall_seen", {7'd0, found}, 8'd1);
        repeat (3) tick();
        bus_if.host_ack = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = bus_if.cpu_rdy;
        end
        check("slow_rdy_back", {7'd0, found}, 8'd1);
        check("slow_no_timeout", {7'd0, bus_if.timeout_err}, 8'd0);
        tick();

        // slow access, instantaneous host: RDY low for 2*SS+2 edges
        start_cycle(1'b1, 1'b0);
        bus_if.host_ack = 1'b1;
        lowcnt = bus_if.cpu_rdy ? 0 : 1;
        found  = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (!bus_if.host_req) bus_if.host_ack = 1'b0;
            if (!bus_if.cpu_rdy) lowcnt++;
            found = bus_if.cpu_rdy;
        end
        check("fast_host_low_edges", 8'(lowcnt), 8'd6);
        tick();

        // request timeout with a silent host
        start_cycle(1'b1, 1'b0);
        repeat (7) tick();
        check("tmo_req_still_up", {7'd0, bus_if.host_req}, 8'd1);
        check("tmo_not_yet", {7'd0, bus_if.timeout_err}, 8'd0);
        tick();
        check("tmo_req_dropped", {7'd0, bus_if.host_req}, 8'd0);
        check("tmo_flag_set", {7'd0, bus_if.timeout_err}, 8'd1);
        tick();
        check("tmo_back_idle", {7'd0, bus_if.cpu_rdy}, 8'd1);
        bus_if.err_clr = 1'b1;
        tick();
        bus_if.err_clr = 1'b0;
        check("tmo_cleared", {7'd0, bus_if.timeout_err}, 8'd0);

        // release timeout while err_clr is held: set wins
        start_cycle(1'b1, 1'b0);
        bus_if.host_ack = 1'b1;
        bus_if.err_clr  = 1'b1;
        repeat (10) tick();
        check("rel_tmo_busy", {7'd0, bus_if.busy}, 8'd1);
        check("rel_tmo_not_yet", {7'd0, bus_if.timeout_err}, 8'd0);
        tick();
        check("rel_tmo_flag_wins", {7'd0, bus_if.timeout_err}, 8'd1);
        check("rel_tmo_rdy", {7'd0, bus_if.cpu_rdy}, 8'd1);
        bus_if.err_clr  = 1'b0;
        bus_if.host_ack = 1'b0;
        tick();
        bus_if.err_clr = 1'b1;
        tick();
        bus_if.err_clr = 1'b0;
        check("rel_tmo_cleared", {7'd0, bus_if.timeout_err}, 8'd0);
        repeat (3) tick();

        // asynchronous reset in the middle of a request
        start_cycle(1'b1, 1'b0);
        tick();
        check("rst_req_up", {7'd0, bus_if.host_req}, 8'd1);
        #1 resetb = 1'b0;
        #1;
        check("rst_req_low", {7'd0, bus_if.host_req}, 8'd0);
        check("rst_rdy_high", {7'd0, bus_if.cpu_rdy}, 8'd1);
        check("rst_state_idle", {6'd0, bus_if.state}, {6'd0, ST_IDLE});
        #1 resetb = 1'b1;
        repeat (2) tick();

        // clock stopped during a fast wait
        start_cycle(1'b0, 1'b0);
        check("stop_rdy_e0", {7'd0, bus_if.cpu_rdy}, 8'd0);
        clk_en = 1'b0;
        #23;
        check("stop_frozen_rdy", {7'd0, bus_if.cpu_rdy}, 8'd0);
        check("stop_frozen_state", {6'd0, bus_if.state}, {6'd0, ST_WAIT});
        clk_en = 1'b1;
        tick();
        check("stop_rdy_e1", {7'd0, bus_if.cpu_rdy}, 8'd0);
        tick();
        check("stop_rdy_e2", {7'd0, bus_if.cpu_rdy}, 8'd1);

        // randomized traffic with a host of random latency
        delay = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            bus_if.cyc_valid = ($urandom_range(0, 2) == 0);
            bus_if.cyc_slow  = ($urandom_range(0, 1) == 1);
            bus_if.div4not2  = ($urandom_range(0, 1) == 1);
            bus_if.err_clr   = ($urandom_range(0, 9) == 0);
            if (bus_if.host_req != bus_if.host_ack) begin
                if (delay == 0) begin
                    bus_if.host_ack = bus_if.host_req;
                    delay = $urandom_range(0, 9);
                end else begin
                    delay--;
                end
            end
        end
        bus_if.cyc_valid = 1'b0;
        bus_if.err_clr   = 1'b0;
        bus_if.host_ack  = 1'b0;
        repeat (30) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
